// File: rtl/cb_config_xbar_if.sv
// Track-side bundle of the connection block: scan port plus the four input and output buses.
// The block drives prog_out and out1..out4; the routing channel drives everything else.
interface cb_config_xbar_if;
  logic       prog_en;
  logic       prog_in;
  logic       prog_out;
  logic [3:0] in1;
  logic [3:0] in2;
  logic [3:0] in3;
  logic [3:0] in4;
  logic [3:0] out1;
  logic [3:0] out2;
  logic [3:0] out3;
  logic [3:0] out4;

  modport master (
    output prog_en, prog_in, in1, in2, in3, in4,
    input  prog_out, out1, out2, out3, out4
  );

  modport slave (
    input  prog_en, prog_in, in1, in2, in3, in4,
    output prog_out, out1, out2, out3, out4
  );
endinterface

// File: rtl/cb_config_xbar.sv
// Serially programmed 16x16 connection block: each output bit picks any of 16 track bits,
// routed combinationally or through a per-port output register, under a 69-bit scan config.
module cb_config_xbar (
  input  logic              clb_clk,
  input  logic              rst,
  cb_config_xbar_if.slave   bus
);
  localparam int CFG_LEN = 69;

  logic [CFG_LEN-1:0] cfg_q, cfg_d;
  logic [15:0]        oreg_q;
  logic [15:0]        src;
  logic [15:0]        mux_d;
  logic [15:0]        out_d;
  logic               gate;

  assign src = {bus.in4, bus.in3, bus.in2, bus.in1};

  // New bits enter at the top so the first bit of a stream settles in cfg[0].
  always_comb begin
    cfg_d = cfg_q;
    if (bus.prog_en) cfg_d = {bus.prog_in, cfg_q[CFG_LEN-1:1]};
  end

  always_comb begin
    mux_d = '0;
    for (int k = 0; k < 16; k++) mux_d[k] = src[cfg_q[4*k +: 4]];
  end

  always_ff @(posedge clb_clk) begin
    if (rst) begin
      cfg_q  <= '0;
      oreg_q <= '0;
    end else begin
      cfg_q  <= cfg_d;
      oreg_q <= mux_d;
    end
  end

  // Tracks are held low while a config is being shifted or the block is disabled.
  assign gate = rst | bus.prog_en | ~cfg_q[68];

  always_comb begin
    out_d = '0;
    for (int k = 0; k < 16; k++) begin
      if (!gate) out_d[k] = cfg_q[64 + k/4] ? oreg_q[k] : mux_d[k];
    end
  end

  assign bus.out1     = out_d[3:0];
  assign bus.out2     = out_d[7:4];
  assign bus.out3     = out_d[11:8];
  assign bus.out4     = out_d[15:12];
  assign bus.prog_out = cfg_q[0];
endmodule

// File: tb/tb_cb_config_xbar.sv
// Bench for cb_config_xbar: table of routed configurations, hand sequences for the
// multi-cycle cases, and randomized traffic against a bitstream-queue reference model.
module tb_cb_config_xbar;
  logic clb_clk = 1'b0;
  logic rst;
  always #5 clb_clk = ~clb_clk;

  cb_config_xbar_if bus();

  cb_config_xbar dut (
    .clb_clk (clb_clk),
    .rst     (rst),
    .bus     (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: the last 69 scanned bits, oldest first; entry i is config bit i.
  bit        q[$];
  bit [15:0] m_oreg;

  typedef struct {
    logic [68:0] cfg;
    logic [15:0] src;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[7];

  function automatic logic [15:0] src_now();
    return {bus.in4, bus.in3, bus.in2, bus.in1};
  endfunction

  function automatic logic [15:0] dout();
    return {bus.out4, bus.out3, bus.out2, bus.out1};
  endfunction

  function automatic logic [15:0] model_mux(logic [15:0] s);
    logic [15:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      int sel;
      sel = 0;
      for (int j = 0; j < 4; j++) if (q[4*k+j]) sel += (1 << j);
      r[k] = s[sel];
    end
    return r;
  endfunction

  function automatic logic [15:0] model_out();
    logic [15:0] r, mx;
    r  = '0;
    mx = model_mux(src_now());
    if (rst || bus.prog_en || !q[68]) return r;
    for (int k = 0; k < 16; k++) r[k] = q[64 + k/4] ? m_oreg[k] : mx[k];
    return r;
  endfunction

  task automatic model_edge();
    if (rst) begin
      q.delete();
      repeat (69) q.push_back(1'b0);
      m_oreg = '0;
    end else begin
      m_oreg = model_mux(src_now());
      if (bus.prog_en) begin
        q.push_back(bus.prog_in);
        void'(q.pop_front());
      end
    end
  endtask

  task automatic tick();
    @(posedge clb_clk);
    model_edge();
    #1;
  endtask

  task automatic check16(string nm, logic [15:0] act, logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_all(string nm);
    check16(nm, dout(), model_out());
    check16({nm, "/prog_out"}, {15'b0, bus.prog_out}, {15'b0, q[0]});
  endtask

  task automatic set_src(logic [15:0] s);
    bus.in1 = s[3:0];
    bus.in2 = s[7:4];
    bus.in3 = s[11:8];
    bus.in4 = s[15:12];
  endtask

  task automatic reset_cycle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic load_cfg(logic [68:0] v);
    rst         = 1'b0;
    bus.prog_en = 1'b1;
    for (int i = 0; i < 69; i++) begin
      bus.prog_in = v[i];
      tick();
    end
    bus.prog_en = 1'b0;
    bus.prog_in = 1'b0;
  endtask

  localparam logic [63:0] IDENT = 64'hFEDCBA9876543210;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [68:0] s;
    rst         = 1'b1;
    bus.prog_en = 1'b0;
    bus.prog_in = 1'b0;
    set_src(16'h0);
    repeat (69) q.push_back(1'b0);
    m_oreg = '0;

    // Reset state
    tick();
    set_src(16'hFFFF);
    #1;
    check16("reset_out", dout(), 16'h0);
    check16("reset_prog_out", {15'b0, bus.prog_out}, 16'h0);
    rst = 1'b0;
    #1;
    check16("post_reset_out", dout(), 16'h0);

    // Routed configurations, all ports combinational
    tbl[0] = '{{1'b1, 4'h0, IDENT},                  16'hC35A, 16'hC35A};
    tbl[1] = '{{1'b1, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF}, 16'h8000, 16'hFFFF};
    tbl[2] = '{{1'b1, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF}, 16'h0000, 16'h0000};
    tbl[3] = '{{1'b0, 4'h0, IDENT},                  16'hFFFF, 16'h0000};
    tbl[4] = '{{1'b1, 4'h0, 64'h0123456789ABCDEF},   16'h0001, 16'h8000};
    tbl[5] = '{{1'b1, 4'h0, 64'h0},                  16'h0001, 16'hFFFF};
    tbl[6] = '{{1'b1, 4'h0, 64'h0},                  16'hFFFE, 16'h0000};
    for (int i = 0; i < 7; i++) begin
      reset_cycle();
      load_cfg(tbl[i].cfg);
      set_src(tbl[i].src);
      #1;
      check16($sformatf("table%0d", i), dout(), tbl[i].exp);
      check_all($sformatf("table%0d_model", i));
    end

    // Registered mode: out1 follows in1 one edge late
    reset_cycle();
    load_cfg({1'b1, 4'hF, IDENT});
    set_src(16'h0000);
    tick();
    bus.in1 = 4'h9;
    #1;
    check16("reg_hold", {12'h0, bus.out1}, 16'h0000);
    tick();
    check16("reg_update", {12'h0, bus.out1}, 16'h0009);

    // prog_en gates outputs at once while the config keeps shifting
    reset_cycle();
    load_cfg({1'b1, 4'h0, IDENT});
    set_src(16'hC35A);
    #1;
    check16("gate_before", dout(), 16'hC35A);
    bus.prog_en = 1'b1;
    bus.prog_in = 1'b0;
    #1;
    check16("gate_prog_en", dout(), 16'h0000);
    repeat (4) tick();
    check16("gate_shifted", {15'b0, bus.prog_out}, 16'h0001);
    check_all("gate_model");
    bus.prog_en = 1'b0;

    // Scan chain: second stream pushes the first one out, bit 0 first
    reset_cycle();
    s = {1'b1, 4'($urandom), $urandom, $urandom};
    load_cfg(s);
    bus.prog_en = 1'b1;
    bus.prog_in = 1'b0;
    for (int i = 0; i < 69; i++) begin
      #1;
      check16($sformatf("scan_bit%0d", i), {15'b0, bus.prog_out}, {15'b0, s[i]});
      tick();
    end
    bus.prog_en = 1'b0;
    set_src(16'hFFFF);
    #1;
    check16("scan_after_out", dout(), 16'h0);
    check16("scan_after_prog_out", {15'b0, bus.prog_out}, 16'h0);

    // Reset in the middle of a stream, then full reload
    reset_cycle();
    bus.prog_en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      bus.prog_in = 1'b1;
      tick();
    end
    bus.prog_en = 1'b0;
    load_cfg({1'b1, 4'h0, IDENT});
    bus.prog_en = 1'b1;
    bus.prog_in = 1'b1;
    tick();
    bus.prog_en = 1'b1;
    rst = 1'b1;
    #1;
    check16("midrst_rst_high", dout(), 16'h0);
    tick();
    rst         = 1'b0;
    bus.prog_en = 1'b0;
    #1;
    check16("midrst_out", dout(), 16'h0);
    check16("midrst_prog_out", {15'b0, bus.prog_out}, 16'h0);
    load_cfg({1'b1, 4'h0, IDENT});
    set_src(16'hC35A);
    #1;
    check16("midrst_reload", dout(), 16'hC35A);

    // Randomized traffic against the model
    for (int c = 0; c < 6; c++) begin
      reset_cycle();
      load_cfg({($urandom_range(0, 7) != 0), 4'($urandom), $urandom, $urandom});
      for (int n = 0; n < 80; n++) begin
        int r;
        r           = $urandom_range(0, 99);
        rst         = (r < 2);
        bus.prog_en = (r >= 2 && r < 8);
        bus.prog_in = 1'($urandom);
        set_src(16'($urandom));
        #1;
        check_all($sformatf("rand_c%0d_n%0d", c, n));
        tick();
      end
      rst         = 1'b0;
      bus.prog_en = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cb_config_xbar.md
Name:
cb_config_xbar

Overview:
- Serially programmed FPGA connection block: routes any of 16 incoming track bits (four 4-bit buses) to each of 16 outgoing bits (four 4-bit buses).
- Routing comes from a 69-bit configuration shift register loaded through a daisy-chainable scan port (prog_in/prog_out).
- Sits between routing channels and a CLB; configuration chains to neighbouring blocks via prog_out.

Parameters:
- None. Fixed-size block; CFG_LEN = 69 is an internal constant.

Ports:
- clb_clk  in  1  sole clock; shift register, output registers and all state on rising edge
- rst  in  1  synchronous reset, active-high
- prog_en  in  1  shift enable for configuration register
- prog_in  in  1  serial configuration data in
- prog_out  out  1  serial configuration data out (chain to next block)
- in1, in2, in3, in4  in  4 each  incoming track buses
- out1, out2, out3, out4  out  4 each  routed output buses

Behaviour:
- Single clock domain, clb_clk. No separate programming clock.
- Config register: cfg[68:0].
  - On rising edge with rst=1: cfg <= 0.
  - Else if prog_en=1: cfg <= {prog_in, cfg[68:1]}.
  - Else: cfg holds.
  - The first bit shifted in ends at cfg[0] after 69 enabled edges, so bitstream bit i maps to cfg[i].
- prog_out = cfg[0], combinational from the register, so it is the bit leaving on the next enabled edge.
  - Shifting a second 69-bit stream returns the first stream on prog_out, bit 0 first.
- Source vector: src[15:0] = {in4, in3, in2, in1}, with src[0] = in1[0] and src[15] = in4[3].
- Output bit index k = 0..15 maps to {out4, out3, out2, out1}[k].
- Field map:
  - cfg[4k+3:4k]: sel_k, a 4-bit source index for output bit k; mux_k = src[sel_k].
  - cfg[64+p]: reg_mode for out(p+1), p = 0..3. 1 = registered, 0 = combinational.
  - cfg[68]: global enable. 0 forces all outputs to 0.
- Output register oreg[15:0]:
  - rst=1: cleared to 0.
  - Otherwise loads mux[15:0] every edge, regardless of prog_en.
- Output value for bit k:
  - 0 if rst=1, prog_en=1, or cfg[68]=0.
  - Else oreg[k] if reg_mode of its port = 1.
  - Else mux_k, which is combinational, zero-latency, same cycle.
- Latency:
  - Combinational mode: 0 cycles from input change.
  - Registered mode: output reflects inputs sampled at the previous rising edge.
- Outputs are forced low while prog_en=1 so partially shifted configs never drive tracks.
- Simultaneous rst and prog_en: rst wins; cfg cleared, no shift.
- Reset mid-programming: cfg cleared; the partial stream is discarded and must be reshifted in full.
- More than 69 enabled shifts: older bits fall out via prog_out. The last 69 bits define the config.
- Reset values: cfg = 0, oreg = 0, out1..out4 = 0, prog_out = 0.
- No X propagation: every select value 0..15 is legal.

Test Plan:
- Identity route: rst 1 cycle, shift 69 bits with cfg[63:0] = 64'hFEDCBA9876543210, cfg[67:64] = 0, cfg[68] = 1, prog_en low. Then in1=4'hA, in2=4'h5, in3=4'h3, in4=4'hC -> out1=4'hA, out2=4'h5, out3=4'h3, out4=4'hC in the same cycle.
- Broadcast/swap: all sel = 4'hF, enable = 1, in4 = 4'b1000 -> all outputs 4'hF. Then in4 = 4'b0000 -> all outputs 4'h0.
- Registered mode: identity sels, cfg[67:64] = 4'b1111. Change in1 from 4'h0 to 4'h9 just after an edge -> out1 stays 4'h0 until the next rising edge, then 4'h9.
- Enable/prog gating: identity config with cfg[68] = 0 -> all outputs 0 for any inputs. With a valid config, raise prog_en -> outputs 0 immediately, while cfg keeps shifting.
- Scan chain: load random 69-bit stream S, then shift 69 zeros -> prog_out sequence equals S[0..68]. Afterwards cfg = 0 and outputs 0.
- Reset mid-stream: after 30 of 69 bits, assert rst for one edge -> cfg = 0, prog_out = 0, outputs 0. A full reload then behaves as the identity test.
